// File: rtl/vga_ctrl_if.sv
// Pixel-side and DAC-side signals of the VGA timing generator.
// The master modport is the controller; the slave modport is the pixel-colour host.
interface vga_ctrl_if;
  logic [9:0]  red;
  logic [9:0]  green;
  logic [9:0]  blue;
  logic [10:0] cur_x;
  logic [10:0] cur_y;
  logic        request;
  logic [9:0]  vga_r;
  logic [9:0]  vga_g;
  logic [9:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank;
  logic        vga_clock;

  modport master (
    input  red, green, blue,
    output cur_x, cur_y, request,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank, vga_clock
  );

  modport slave (
    output red, green, blue,
    input  cur_x, cur_y, request,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank, vga_clock
  );
endinterface

// File: rtl/vga_ctrl.sv
// Free-running VGA timing generator with colour gating (640x480@60 by default).
// All outputs decode combinationally from the horizontal and vertical counters.
module vga_ctrl #(
  parameter int unsigned HSync  = 96,
  parameter int unsigned HBack  = 48,
  parameter int unsigned HAct   = 640,
  parameter int unsigned HFront = 16,
  parameter int unsigned VSync  = 2,
  parameter int unsigned VBack  = 33,
  parameter int unsigned VAct   = 480,
  parameter int unsigned VFront = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  vga_ctrl_if.master    vga
);

  localparam int unsigned HTotal = HSync + HBack + HAct + HFront;
  localparam int unsigned VTotal = VSync + VBack + VAct + VFront;
  localparam int unsigned XStart = HSync + HBack;
  localparam int unsigned YStart = VSync + VBack;

  localparam logic [10:0] HLast   = 11'(HTotal - 1);
  localparam logic [10:0] VLast   = 11'(VTotal - 1);
  localparam logic [10:0] HSyncW  = 11'(HSync);
  localparam logic [10:0] VSyncW  = 11'(VSync);
  localparam logic [10:0] XStartW = 11'(XStart);
  localparam logic [10:0] XEndW   = 11'(XStart + HAct);
  localparam logic [10:0] YStartW = 11'(YStart);
  localparam logic [10:0] YEndW   = 11'(YStart + VAct);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        h_act, v_act, active;

  // The vertical counter only advances on the horizontal wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HLast) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VLast) ? 11'd0 : v_cnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_act  = (h_cnt_q >= XStartW) && (h_cnt_q < XEndW);
  assign v_act  = (v_cnt_q >= YStartW) && (v_cnt_q < YEndW);
  assign active = h_act && v_act;

  assign vga.cur_x     = h_act ? (h_cnt_q - XStartW) : 11'd0;
  assign vga.cur_y     = v_act ? (v_cnt_q - YStartW) : 11'd0;
  assign vga.request   = active;
  assign vga.vga_blank = active;
  assign vga.vga_hs    = (h_cnt_q >= HSyncW);
  assign vga.vga_vs    = (v_cnt_q >= VSyncW);

  // Zero-latency pass-through: the host answers X/Y within the same cycle.
  assign vga.vga_r = active ? vga.red   : 10'd0;
  assign vga.vga_g = active ? vga.green : 10'd0;
  assign vga.vga_b = active ? vga.blue  : 10'd0;

  assign vga.vga_clock = ~clk_i;

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench for vga_ctrl; full horizontal timing, shortened vertical timing
// (2 sync + 3 back + 6 active + 2 front = 13 lines) so whole frames stay short.
module tb_vga_ctrl;
  localparam int HTot  = 800;
  localparam int VTot  = 13;
  localparam int Frame = HTot * VTot;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  int   pos;

  vga_ctrl_if vif ();

  vga_ctrl #(
    .HSync (96), .HBack (48), .HAct (640), .HFront (16),
    .VSync (2),  .VBack (3),  .VAct (6),   .VFront (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .vga    (vif.master)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    pos++;
  endtask

  // Advance to line v, column h of the current frame (or the next one if already past).
  task automatic goto(input int v, input int h);
    int t;
    t = (pos / Frame) * Frame + v * HTot + h;
    if (t < pos) t += Frame;
    while (pos < t) step();
  endtask

  task automatic set_colour(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    vif.red   = r;
    vif.green = g;
    vif.blue  = b;
  endtask

  task automatic test_reset();
    set_colour(10'h3FF, 10'h155, 10'h0AA);
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({vif.vga_hs, vif.vga_vs, vif.request, vif.vga_blank} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {vif.vga_hs, vif.vga_vs, vif.request, vif.vga_blank});
    end
    n_cmp++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b, vif.cur_x, vif.cur_y} !== 52'd0) begin
      n_fail++;
      $display("FAIL reset_data: got rgb %h %h %h x %0d y %0d want all 0",
               vif.vga_r, vif.vga_g, vif.vga_b, vif.cur_x, vif.cur_y);
    end
    n_cmp++;
    if (vif.vga_clock !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_clock_low: got %b want 1", vif.vga_clock);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (vif.vga_clock !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clock_high: got %b want 0", vif.vga_clock);
    end
    n_cmp++;
    if (vif.vga_hs !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held_hs: got %b want 0", vif.vga_hs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pos = 0;
    #1;
    n_cmp++;
    if ({vif.vga_hs, vif.vga_vs, vif.request, vif.vga_r} !== 13'd0) begin
      n_fail++;
      $display("FAIL cycle0: got hs %b vs %b req %b r %h want 0",
               vif.vga_hs, vif.vga_vs, vif.request, vif.vga_r);
    end
  endtask

  task automatic test_hsync();
    goto(0, 95);
    n_cmp++;
    if (vif.vga_hs !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_at_95: got %b want 0", vif.vga_hs);
    end
    goto(0, 96);
    n_cmp++;
    if (vif.vga_hs !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_at_96: got %b want 1", vif.vga_hs);
    end
    goto(0, 799);
    n_cmp++;
    if ({vif.vga_hs, vif.vga_vs} !== 2'b10) begin
      n_fail++;
      $display("FAIL line0_end: got hs/vs %b want 10", {vif.vga_hs, vif.vga_vs});
    end
    goto(1, 0);
    n_cmp++;
    if ({vif.vga_hs, vif.vga_vs} !== 2'b00) begin
      n_fail++;
      $display("FAIL line1_start: got hs/vs %b want 00", {vif.vga_hs, vif.vga_vs});
    end
    goto(1, 96);
    n_cmp++;
    if ({vif.vga_hs, vif.vga_vs} !== 2'b10) begin
      n_fail++;
      $display("FAIL line1_hs_rise: got hs/vs %b want 10", {vif.vga_hs, vif.vga_vs});
    end
    goto(2, 0);
    n_cmp++;
    if ({vif.vga_hs, vif.vga_vs} !== 2'b01) begin
      n_fail++;
      $display("FAIL vs_rise_line2: got hs/vs %b want 01", {vif.vga_hs, vif.vga_vs});
    end
  endtask

  task automatic test_active();
    set_colour(10'h3FF, 10'h155, 10'h0AA);
    goto(5, 143);
    n_cmp++;
    if ({vif.request, vif.vga_blank, vif.cur_x} !== 13'd0) begin
      n_fail++;
      $display("FAIL pre_active: got req %b blank %b x %0d want 0 0 0",
               vif.request, vif.vga_blank, vif.cur_x);
    end
    goto(5, 144);
    n_cmp++;
    if ({vif.request, vif.vga_blank, vif.cur_x, vif.cur_y} !== {2'b11, 22'd0}) begin
      n_fail++;
      $display("FAIL first_pixel: got req %b blank %b x %0d y %0d want 1 1 0 0",
               vif.request, vif.vga_blank, vif.cur_x, vif.cur_y);
    end
    n_cmp++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== {10'h3FF, 10'h155, 10'h0AA}) begin
      n_fail++;
      $display("FAIL first_pixel_rgb: got %h %h %h want 3ff 155 0aa",
               vif.vga_r, vif.vga_g, vif.vga_b);
    end
    goto(5, 783);
    n_cmp++;
    if ({vif.request, vif.cur_x} !== {1'b1, 11'd639}) begin
      n_fail++;
      $display("FAIL last_pixel: got req %b x %0d want 1 639", vif.request, vif.cur_x);
    end
    goto(5, 784);
    n_cmp++;
    if ({vif.request, vif.vga_blank, vif.cur_x} !== 13'd0) begin
      n_fail++;
      $display("FAIL post_active: got req %b blank %b x %0d want 0 0 0",
               vif.request, vif.vga_blank, vif.cur_x);
    end
    n_cmp++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== 30'd0) begin
      n_fail++;
      $display("FAIL post_active_rgb: got %h %h %h want 0 0 0",
               vif.vga_r, vif.vga_g, vif.vga_b);
    end
    goto(7, 400);
    n_cmp++;
    if ({vif.cur_x, vif.cur_y} !== {11'd256, 11'd2}) begin
      n_fail++;
      $display("FAIL mid_xy: got x %0d y %0d want 256 2", vif.cur_x, vif.cur_y);
    end
    set_colour(10'h001, 10'h2AA, 10'h3FF);
    #1;
    n_cmp++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b} !== {10'h001, 10'h2AA, 10'h3FF}) begin
      n_fail++;
      $display("FAIL same_cycle_rgb: got %h %h %h want 001 2aa 3ff",
               vif.vga_r, vif.vga_g, vif.vga_b);
    end
    goto(8, 10);
    n_cmp++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b, vif.vga_blank, vif.cur_y} !== {31'd0, 11'd3}) begin
      n_fail++;
      $display("FAIL hblank_rgb: got %h %h %h blank %b y %0d want 0 0 0 0 3",
               vif.vga_r, vif.vga_g, vif.vga_b, vif.vga_blank, vif.cur_y);
    end
  endtask

  task automatic test_last_line();
    goto(10, 144);
    n_cmp++;
    if ({vif.request, vif.cur_y} !== {1'b1, 11'd5}) begin
      n_fail++;
      $display("FAIL last_line: got req %b y %0d want 1 5", vif.request, vif.cur_y);
    end
    goto(10, 783);
    n_cmp++;
    if ({vif.cur_x, vif.cur_y} !== {11'd639, 11'd5}) begin
      n_fail++;
      $display("FAIL last_corner: got x %0d y %0d want 639 5", vif.cur_x, vif.cur_y);
    end
    goto(11, 144);
    n_cmp++;
    if ({vif.request, vif.cur_y, vif.vga_vs} !== {1'b0, 11'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL front_porch: got req %b y %0d vs %b want 0 0 1",
               vif.request, vif.cur_y, vif.vga_vs);
    end
  endtask

  task automatic test_frame();
    int lows;
    goto(0, 0);
    n_cmp++;
    if ({vif.vga_hs, vif.vga_vs, vif.cur_y} !== 13'd0) begin
      n_fail++;
      $display("FAIL frame_wrap: got hs %b vs %b y %0d want 0 0 0",
               vif.vga_hs, vif.vga_vs, vif.cur_y);
    end
    lows = 0;
    for (int i = 0; i < Frame; i++) begin
      if (vif.vga_vs === 1'b0) lows++;
      step();
    end
    n_cmp++;
    if (lows !== 1600) begin
      n_fail++;
      $display("FAIL vs_low_clocks: got %0d want 1600", lows);
    end
    n_cmp++;
    if ({vif.vga_hs, vif.vga_vs} !== 2'b00) begin
      n_fail++;
      $display("FAIL next_frame_start: got hs/vs %b want 00", {vif.vga_hs, vif.vga_vs});
    end
  endtask

  task automatic test_mid_reset();
    set_colour(10'h3FF, 10'h155, 10'h0AA);
    goto(7, 300);
    n_cmp++;
    if ({vif.request, vif.vga_r} !== {1'b1, 10'h3FF}) begin
      n_fail++;
      $display("FAIL pre_reset_active: got req %b r %h want 1 3ff", vif.request, vif.vga_r);
    end
    #5;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({vif.vga_hs, vif.vga_vs, vif.request, vif.vga_blank} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset_ctrl: got %b want 0000",
               {vif.vga_hs, vif.vga_vs, vif.request, vif.vga_blank});
    end
    n_cmp++;
    if ({vif.vga_r, vif.vga_g, vif.vga_b, vif.cur_x, vif.cur_y} !== 52'd0) begin
      n_fail++;
      $display("FAIL async_reset_data: got rgb %h %h %h x %0d y %0d want all 0",
               vif.vga_r, vif.vga_g, vif.vga_b, vif.cur_x, vif.cur_y);
    end
    n_cmp++;
    if (vif.vga_clock !== ~clk) begin
      n_fail++;
      $display("FAIL async_reset_clock: got %b want %b", vif.vga_clock, ~clk);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pos = 0;
    goto(0, 95);
    n_cmp++;
    if ({vif.vga_hs, vif.vga_vs} !== 2'b00) begin
      n_fail++;
      $display("FAIL restart_95: got hs/vs %b want 00", {vif.vga_hs, vif.vga_vs});
    end
    goto(0, 96);
    n_cmp++;
    if (vif.vga_hs !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_hs_rise: got %b want 1", vif.vga_hs);
    end
    goto(5, 144);
    n_cmp++;
    if ({vif.request, vif.cur_x, vif.cur_y} !== {1'b1, 22'd0}) begin
      n_fail++;
      $display("FAIL restart_first_pixel: got req %b x %0d y %0d want 1 0 0",
               vif.request, vif.cur_x, vif.cur_y);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    pos    = 0;
    rst_n  = 1'b0;
    set_colour(10'h000, 10'h000, 10'h000);
    test_reset();
    test_hsync();
    test_active();
    test_last_line();
    test_frame();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
